aes_round_mix_stage: RTL and testbench

Second half of one unrolled AES-128 encryption round. It consumes the 128-bit registered SubBytes output from the 16-S-box array of the same round and applies ShiftRows, then MixColumns (bypassed on the final round), then AddRoundKey. The result is registered behind a valid/ready handshake with a skid buffer, which absorbs downstream stalls without a combinational ready path. Output feeds the next round's SubBytes array, or the ciphertext port after round 10.

---
 rtl/aes_pkg.sv | 35 +++
 rtl/aes_round_mix_stage_if.sv | 33 +++
 rtl/aes_mix_column.sv | 22 ++
 rtl/aes_round_mix_stage.sv | 103 ++++++++++
 tb/tb_aes_round_mix_stage.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, byte-permutation table, GF(2^8) helpers and
// skid-buffer state encoding for the round mix stage.
package aes_pkg;

  localparam int AES_STATE_W = 128;

  typedef logic [0:AES_STATE_W-1] state_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_st_e;

  // ShiftRows source byte for each destination byte (column-major).
  localparam logic [3:0] SR_IDX [16] = '{
    4'd0,  4'd5,  4'd10, 4'd15,
    4'd4,  4'd9,  4'd14, 4'd3,
    4'd8,  4'd13, 4'd2,  4'd7,
    4'd12, 4'd1,  4'd6,  4'd11
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gmul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

endpackage

// File: rtl/aes_round_mix_stage_if.sv
// Upstream/downstream valid-ready bundle of the round mix stage.
// master: round wrapper side; slave: the stage itself.
interface aes_round_mix_stage_if #(
  parameter int TAG_W = 4
);
  import aes_pkg::*;

  logic             in_valid;
  logic             in_ready;
  state_t           in_state;
  state_t           in_key;
  logic             in_final;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  state_t           out_state;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_state, in_key,
    output in_final, in_tag, out_ready,
    input  in_ready, out_valid,
    input  out_state, out_tag
  );

  modport slave (
    input  in_valid, in_state, in_key,
    input  in_final, in_tag, out_ready,
    output in_ready, out_valid,
    output out_state, out_tag
  );

endinterface

// File: rtl/aes_mix_column.sv
// One MixColumns column: col_i[31:24] is row 0.
// Ports: col_i (32b column in), col_o (32b column out).
module aes_mix_column
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col_i[31:24];
  assign a1 = col_i[23:16];
  assign a2 = col_i[15:8];
  assign a3 = col_i[7:0];

  assign col_o[31:24] = gmul2(a0) ^ gmul3(a1) ^ a2 ^ a3;
  assign col_o[23:16] = a0 ^ gmul2(a1) ^ gmul3(a2) ^ a3;
  assign col_o[15:8]  = a0 ^ a1 ^ gmul2(a2) ^ gmul3(a3);
  assign col_o[7:0]   = gmul3(a0) ^ a1 ^ a2 ^ gmul2(a3);

endmodule

// File: rtl/aes_round_mix_stage.sv
// ShiftRows + MixColumns (optional) + AddRoundKey, registered behind a
// skid buffer. Ports: clk, rst (async high), bus (slave handshake).
module aes_round_mix_stage
  import aes_pkg::*;
#(
  parameter int TAG_W       = 4,
  parameter bit FINAL_ROUND = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  aes_round_mix_stage_if.slave   bus
);

  state_t sr, mc, res;
  logic   bypass;

  for (genvar i = 0; i < 16; i++) begin : g_sr
    assign sr[8*i +: 8] = bus.in_state[8*SR_IDX[i] +: 8];
  end

  for (genvar c = 0; c < 4; c++) begin : g_mc
    aes_mix_column u_mc (
      .col_i (sr[32*c +: 32]),
      .col_o (mc[32*c +: 32])
    );
  end

  assign bypass = FINAL_ROUND || bus.in_final;
  assign res    = (bypass ? sr : mc) ^ bus.in_key;

  skid_st_e         st_q, st_d;
  state_t           main_q, main_d;
  state_t           skid_q, skid_d;
  logic [TAG_W-1:0] mtag_q, mtag_d;
  logic [TAG_W-1:0] stag_q, stag_d;
  logic             rdy_q, rdy_d;
  logic             acc;

  assign acc = bus.in_valid && rdy_q;

  always_comb begin
    st_d   = st_q;
    main_d = main_q;
    mtag_d = mtag_q;
    skid_d = skid_q;
    stag_d = stag_q;
    unique case (st_q)
      EMPTY: begin
        if (acc) begin
          main_d = res;
          mtag_d = bus.in_tag;
          st_d   = ONE;
        end
      end
      ONE: begin
        if (acc && bus.out_ready) begin
          main_d = res;
          mtag_d = bus.in_tag;
        end else if (acc) begin
          skid_d = res;
          stag_d = bus.in_tag;
          st_d   = FULL;
        end else if (bus.out_ready) begin
          st_d = EMPTY;
        end
      end
      FULL: begin
        // ready is low here, so only the skid shift can happen.
        if (bus.out_ready) begin
          main_d = skid_q;
          mtag_d = stag_q;
          st_d   = ONE;
        end
      end
      default: st_d = EMPTY;
    endcase
    rdy_d = (st_d != FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= EMPTY;
      main_q <= '0;
      mtag_q <= '0;
      skid_q <= '0;
      stag_q <= '0;
      rdy_q  <= 1'b1;
    end else begin
      st_q   <= st_d;
      main_q <= main_d;
      mtag_q <= mtag_d;
      skid_q <= skid_d;
      stag_q <= stag_d;
      rdy_q  <= rdy_d;
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = (st_q != EMPTY);
  assign bus.out_state = main_q;
  assign bus.out_tag   = mtag_q;

endmodule

// File: tb/tb_aes_round_mix_stage.sv
// Directed bench for aes_round_mix_stage: FIPS-197 vectors, throughput,
// stall, toggling drain and async reset.
module tb_aes_round_mix_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  aes_round_mix_stage_if #(.TAG_W(4)) bus ();

  aes_round_mix_stage #(.TAG_W(4), .FINAL_ROUND(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_round(input logic [127:0] s,
                                             input logic [127:0] k,
                                             input logic fin);
    logic [7:0] a [4][4];
    logic [7:0] m [4][4];
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        a[r][c] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        m[r][c] = fin ? a[r][c] :
          gm(8'h02, a[r][c]) ^ gm(8'h03, a[(r+1)%4][c]) ^
          a[(r+2)%4][c] ^ a[(r+3)%4][c];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(r + 4*c) -: 8] = m[r][c] ^ k[127 - 8*(r + 4*c) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] beat_s(input int i);
    return 128'h00112233445566778899aabbccddeeff ^ {16{8'(i*29 + 3)}};
  endfunction

  function automatic logic [127:0] beat_k(input int i);
    return 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0 + 128'(i*7919);
  endfunction

  task automatic drive(input int i, input logic fin);
    bus.in_valid = 1'b1;
    bus.in_state = beat_s(i);
    bus.in_key   = beat_k(i);
    bus.in_final = fin;
    bus.in_tag   = 4'(i);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_out_valid got %b want 0", bus.out_valid);
    end
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_in_ready got %b want 1", bus.in_ready);
    end
    n_vec++;
    if (bus.out_state !== 128'h0) begin
      n_err++;
      $display("FAIL rst_out_state got %h want 0", bus.out_state);
    end
    n_vec++;
    if (bus.out_tag !== 4'h0) begin
      n_err++;
      $display("FAIL rst_out_tag got %h want 0", bus.out_tag);
    end
    rst = 1'b0;
  endtask

  task automatic test_fips_round1();
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_state  = 128'hd42711aee0bf98f1b8b45de51e415230;
    bus.in_key    = 128'ha0fafe1788542cb123a339392a6c7605;
    bus.in_final  = 1'b0;
    bus.in_tag    = 4'h5;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_vec++;
    if (bus.out_valid !== 1'b1 ||
        bus.out_state !== 128'ha49c7ff2689f352b6b5bea43026a5049) begin
      n_err++;
      $display("FAIL fips_r1 got v=%b %h want v=1 %h", bus.out_valid,
               bus.out_state, 128'ha49c7ff2689f352b6b5bea43026a5049);
    end
    n_vec++;
    if (bus.out_tag !== 4'h5) begin
      n_err++;
      $display("FAIL fips_r1_tag got %h want 5", bus.out_tag);
    end
  endtask

  task automatic test_final_round();
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_state  = 128'he9098972cb31075f3d327d94af2e2cb5;
    bus.in_key    = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    bus.in_final  = 1'b1;
    bus.in_tag    = 4'ha;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_vec++;
    if (bus.out_valid !== 1'b1 ||
        bus.out_state !== 128'h3925841d02dc09fbdc118597196a0b32) begin
      n_err++;
      $display("FAIL final_rnd got v=%b %h want v=1 %h", bus.out_valid,
               bus.out_state, 128'h3925841d02dc09fbdc118597196a0b32);
    end
    n_vec++;
    if (bus.out_tag !== 4'ha) begin
      n_err++;
      $display("FAIL final_rnd_tag got %h want a", bus.out_tag);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] exp;
    bus.out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        exp = ref_round(beat_s(i-1), beat_k(i-1), 1'b0);
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.out_tag !== 4'(i-1) ||
            bus.out_state !== exp) begin
          n_err++;
          $display("FAIL b2b_out%0d got v=%b t=%h %h want v=1 t=%h %h",
                   i-1, bus.out_valid, bus.out_tag, bus.out_state,
                   4'(i-1), exp);
        end
      end
      if (i < 8) begin
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_ready%0d got %b want 1", i, bus.in_ready);
        end
        drive(i, 1'b0);
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    @(negedge clk);
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_idle got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_stall();
    logic [127:0] e0, e1, e2;
    e0 = ref_round(beat_s(20), beat_k(20), 1'b0);
    e1 = ref_round(beat_s(21), beat_k(21), 1'b1);
    e2 = ref_round(beat_s(22), beat_k(22), 1'b0);
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(20, 1'b0);
    @(negedge clk);
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL stall_rdy1 got %b want 1", bus.in_ready);
    end
    drive(21, 1'b1);
    @(negedge clk);
    drive(22, 1'b0);
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (bus.in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL stall_rdy0_%0d got %b want 0", k, bus.in_ready);
      end
      n_vec++;
      if (bus.out_valid !== 1'b1 || bus.out_state !== e0 ||
          bus.out_tag !== 4'(20)) begin
        n_err++;
        $display("FAIL stall_hold_%0d got v=%b t=%h %h want v=1 t=%h %h",
                 k, bus.out_valid, bus.out_tag, bus.out_state, 4'(20), e0);
      end
      if (k < 2) @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.out_state !== e1 ||
        bus.out_tag !== 4'(21) || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL stall_out1 got v=%b r=%b t=%h %h want v=1 r=1 t=%h %h",
               bus.out_valid, bus.in_ready, bus.out_tag, bus.out_state,
               4'(21), e1);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.out_state !== e2 ||
        bus.out_tag !== 4'(22)) begin
      n_err++;
      $display("FAIL stall_out2 got v=%b t=%h %h want v=1 t=%h %h",
               bus.out_valid, bus.out_tag, bus.out_state, 4'(22), e2);
    end
    @(negedge clk);
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stall_idle got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_toggle_drain();
    logic [127:0] eq [$];
    logic [3:0]   tq [$];
    int src;
    src = 0;
    for (int cyc = 0; cyc < 80 && (src < 10 || eq.size() > 0); cyc++) begin
      @(negedge clk);
      bus.out_ready = (cyc % 2) == 1;
      if (bus.out_valid && bus.out_ready) begin
        n_vec++;
        if (eq.size() == 0) begin
          n_err++;
          $display("FAIL tog_extra got t=%h %h want none",
                   bus.out_tag, bus.out_state);
        end else begin
          if (bus.out_state !== eq[0] || bus.out_tag !== tq[0]) begin
            n_err++;
            $display("FAIL tog_out got t=%h %h want t=%h %h",
                     bus.out_tag, bus.out_state, tq[0], eq[0]);
          end
          void'(eq.pop_front());
          void'(tq.pop_front());
        end
      end
      if (src < 10) begin
        drive(30 + src, src[0]);
        if (bus.in_ready) begin
          eq.push_back(ref_round(beat_s(30 + src), beat_k(30 + src), src[0]));
          tq.push_back(4'(30 + src));
          src++;
        end
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    n_vec++;
    if (src != 10 || eq.size() != 0) begin
      n_err++;
      $display("FAIL tog_done got sent=%0d pending=%0d want 10 0",
               src, eq.size());
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL tog_idle got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(40, 1'b0);
    @(negedge clk);
    drive(41, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_vec++;
    if (bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL ar_pre_full got %b want 0", bus.in_ready);
    end
    #1 rst = 1'b1;
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
        bus.out_state !== 128'h0) begin
      n_err++;
      $display("FAIL ar_immediate got v=%b r=%b %h want v=0 r=1 0",
               bus.out_valid, bus.in_ready, bus.out_state);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_state  = 128'hd42711aee0bf98f1b8b45de51e415230;
    bus.in_key    = 128'ha0fafe1788542cb123a339392a6c7605;
    bus.in_final  = 1'b0;
    bus.in_tag    = 4'h3;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.out_tag !== 4'h3 ||
        bus.out_state !== 128'ha49c7ff2689f352b6b5bea43026a5049) begin
      n_err++;
      $display("FAIL ar_after got v=%b t=%h %h want v=1 t=3 %h",
               bus.out_valid, bus.out_tag, bus.out_state,
               128'ha49c7ff2689f352b6b5bea43026a5049);
    end
    @(negedge clk);
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ar_idle got %b want 0", bus.out_valid);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_state  = '0;
    bus.in_key    = '0;
    bus.in_final  = 1'b0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_fips_round1();
    test_final_round();
    test_back_to_back();
    test_stall();
    test_toggle_drain();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
